cp_inserter: RTL and testbench
==============================

# cp_inserter

OFDM transmit-side cyclic-prefix inserter for the 802.22 chain: the counterpart of the receive synchroniser's input stream. Accepts time-domain IFFT output as NFFT-sample symbols on a Wishbone-style streaming sink. Emits each symbol as NCP prefix samples followed by the full NFFT body on a Wishbone-style source. This is the same {Im, Re} sample stream the RX `Synch` block consumes. Ping-pong buffering lets symbol n+1 be written while symbol n is being read.

## Interface
- NFFT, 2048, samples per OFDM symbol (power of two)
- NCP, 512, cyclic-prefix length; 0 < NCP ≤ NFFT
- DW, 32, sample width; DAT[31:16] = Im, DAT[15:0] = Re, two's complement

Clocking and reset: one clock; reset is asynchronous and active-low.
- CLK_I  in  1  clock; all logic rising-edge
- RST_I  in  1  asynchronous, active-low reset
- DAT_I  in  DW  input sample
- CYC_I  in  1  input frame active
- STB_I  in  1  input sample valid
- ACK_O  out  1  input sample accepted this cycle
- DAT_O  out  DW  output sample
- WE_O  out  1  write qualifier; equals STB_O
- STB_O  out  1  output sample valid
- CYC_O  out  1  output frame active
- ACK_I  in  1  downstream accepts DAT_O

## Operation
- Buffer: 2 banks × NFFT words. Write bank pointer `wb`, read bank pointer `rb`, and a full flag per bank.
- Write side:
  - ACK_O = CYC_I & STB_I & !full[wb].
  - On ACK_O, write DAT_I to bank wb at address wcnt, then wcnt++.
  - At wcnt = NFFT−1 with ACK_O: set full[wb], toggle wb, clear wcnt.
- Partial symbol: if CYC_I falls while 0 < wcnt, wcnt clears and the partial data is discarded. full is not set and no output is produced.
- Read FSM, states IDLE, CP, BODY:
  - IDLE → CP when full[rb]. Read address starts at NFFT−NCP.
  - CP: issue NCP reads at addresses NFFT−NCP … NFFT−1, then → BODY.
  - BODY: issue reads at addresses 0 … NFFT−1.
  - On the last BODY transfer: clear full[rb] and toggle rb. If full[new rb], → CP; otherwise → IDLE.
- Output path: RAM read latency is 1 cycle. A 2-entry output skid FIFO absorbs it, and reads are issued only when the FIFO has space. DAT_O/STB_O come from the FIFO head. A transfer happens when STB_O & ACK_I.
- CYC_O: high from the first STB_O of a symbol until the FIFO empties with the FSM in IDLE. Stays high across back-to-back symbols.
- Counters: wcnt and the read counter are log2(NFFT) bits, plus a phase bit for CP/BODY. Addresses wrap modulo NFFT within a bank, so the bank is the address MSB.
- Simultaneous events:
  - The write side completing bank A in the same cycle the read side frees bank B is legal. Both flags update independently.
  - A write into the bank being freed is blocked until full clears; ACK_O sees the registered full.
- Reset mid-operation: all flags, counters and the FIFO clear immediately, and the FSM returns to IDLE. Buffered samples are lost.

## Timing
- Reset values: ACK_O=0, STB_O=0, WE_O=0, CYC_O=0, DAT_O=0; FSM=IDLE, wb=rb=0, full=00.
- ACK_O is combinational from CYC_I/STB_I/full, so a write completes in the same cycle as STB_I.
- Latency: last input ACK_O at edge k → full set at k → first read issued at k+1 → STB_O high after edge k+2.
- DAT_O and STB_O must hold stable while STB_O & !ACK_I.
- Throughput with ACK_I held high: one sample per cycle. There are no gaps between CP and BODY, or between consecutive symbols when the next bank is already full.
- Input throughput: sustained rate averages NFFT/(NFFT+NCP) of a sample per cycle. ACK_O stalls when both banks are full.

## Structure
- Package `ofdm_tx_pkg`:
  - NFFT_DEF, NCP_DEF
  - ADDR_W = $clog2(NFFT)
  - `cp_state_t` enum {IDLE, CP, BODY}
  - the sample field slices (Re/Im)
- Sub-module `cp_dpram`: simple dual-port RAM, 2·NFFT × DW, one write port and one registered read port, inferrable as block RAM.
- Top level holds the write control, read FSM, skid FIFO and CYC_O logic.

## Test plan
- Single symbol, NFFT=16, NCP=4:
  - Stimulus: input DAT_I = n for n = 0…15, ACK_I = 1.
  - Required output: exactly 20 samples, 12,13,14,15,0,1,…,15.
  - CYC_O falls after the last sample; the first STB_O is 3 cycles after the last ACK_O.
- Back-to-back symbols, default parameters:
  - Stimulus: 6 symbols streamed continuously, sample value = symbol·4096 + index.
  - Required output: 6·2560 = 15360 samples, each symbol's first 512 samples equal to indices 1536…2047.
  - STB_O has no bubbles once started; ACK_O deasserts only while both banks are full.
- Backpressure, NFFT=16, NCP=4:
  - Stimulus: random ACK_I at 30% duty.
  - Required: output sequence identical to the no-stall case; DAT_O never changes while STB_O & !ACK_I.
- Partial symbol:
  - Stimulus: 10 samples, CYC_I low for 1 cycle, then a full 16-sample symbol 100…115.
  - Required: output is exactly 112…115, 100…115; the 10 partial samples never appear.
- Bank collision:
  - Stimulus: ACK_I = 0 held for 40 cycles while 3 symbols are offered.
  - Required: ACK_O drops after 32 accepted samples and resumes the cycle after the first BODY completes.
- Reset mid-symbol:
  - Stimulus: assert RST_I low asynchronously (between edges) during BODY.
  - Required: all outputs are 0 immediately; after release, a new symbol 0…15 produces 12…15, 0…15.

Source files
------------

// File: rtl/ofdm_tx_pkg.sv
// Shared definitions for the OFDM transmit chain.
// Contents:
//   NFFT_DEF / NCP_DEF / DW_DEF : default symbol, prefix and sample sizes
//   ADDR_W                      : per-bank address width for the default NFFT
//   cp_state_t                  : cyclic-prefix read sequencer states
//   sample_re / sample_im       : field slices of a {Im, Re} sample
package ofdm_tx_pkg;

   localparam int unsigned NFFT_DEF = 2048;
   localparam int unsigned NCP_DEF  = 512;
   localparam int unsigned DW_DEF   = 32;
   localparam int unsigned ADDR_W   = $clog2(NFFT_DEF);

   // Sample layout: DAT[31:16] = Im, DAT[15:0] = Re, two's complement
   localparam int unsigned RE_LSB  = 0;
   localparam int unsigned IM_LSB  = 16;
   localparam int unsigned FIELD_W = 16;

   typedef enum logic [1:0] {
      IDLE,
      CP,
      BODY
   } cp_state_t;

   function automatic logic signed [FIELD_W-1:0] sample_re(input logic [31:0] s);
      return s[RE_LSB +: FIELD_W];
   endfunction

   function automatic logic signed [FIELD_W-1:0] sample_im(input logic [31:0] s);
      return s[IM_LSB +: FIELD_W];
   endfunction

endpackage

// File: rtl/cp_dpram.sv
// Simple dual-port RAM: one write port, one registered read port.
// No reset on the array or read register so it maps onto block RAM.
// Ports:
//   i_clk                   : clock
//   i_we, i_waddr, i_wdata  : write port
//   i_re, i_raddr           : read request; data appears on o_rdata one cycle later
//   o_rdata                 : registered read data
module cp_dpram #(
   parameter int unsigned DEPTH = 4096,
   parameter int unsigned AW    = 12,
   parameter int unsigned DW    = 32
) (
   input  logic          i_clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [DW-1:0] i_wdata,
   input  logic          i_re,
   input  logic [AW-1:0] i_raddr,
   output logic [DW-1:0] o_rdata
);

   logic [DW-1:0] r_mem [DEPTH];
   logic [DW-1:0] r_rdata;

   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
      if (i_re) begin
         r_rdata <= r_mem[i_raddr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/cp_inserter.sv
// OFDM transmit cyclic-prefix inserter.
// Accepts NFFT-sample symbols on a Wishbone-style sink and emits each one as its last
// NCP samples followed by the full NFFT body on a Wishbone-style source. Two RAM banks
// ping-pong so the next symbol can be written while the current one is read out.
// Ports:
//   CLK_I        : clock, rising edge
//   RST_I        : asynchronous active-low reset
//   DAT_I/CYC_I/STB_I, ACK_O : sample sink
//   DAT_O/STB_O/WE_O/CYC_O, ACK_I : sample source
module cp_inserter
   import ofdm_tx_pkg::*;
#(
   parameter int unsigned NFFT = NFFT_DEF,
   parameter int unsigned NCP  = NCP_DEF,
   parameter int unsigned DW   = DW_DEF
) (
   input  logic          CLK_I,
   input  logic          RST_I,
   input  logic [DW-1:0] DAT_I,
   input  logic          CYC_I,
   input  logic          STB_I,
   output logic          ACK_O,
   output logic [DW-1:0] DAT_O,
   output logic          WE_O,
   output logic          STB_O,
   output logic          CYC_O,
   input  logic          ACK_I
);

   localparam int unsigned   AW       = $clog2(NFFT);
   localparam logic [AW-1:0] CpStart  = AW'(NFFT - NCP);
   localparam logic [AW-1:0] CpLast   = AW'(NCP - 1);
   localparam logic [AW-1:0] BodyLast = AW'(NFFT - 1);

   // Write side
   logic          r_wb;
   logic [AW-1:0] r_wcnt;
   logic          w_ack;
   logic          w_wr_last;

   // Bank flags and read sequencer
   logic [1:0]    r_full;
   logic [1:0]    w_full_d;
   logic          r_rb;
   cp_state_t     r_state;
   cp_state_t     w_state_d;
   logic [AW-1:0] r_rcnt;
   logic [AW-1:0] w_rcnt_d;
   logic [AW-1:0] w_raddr;
   logic          w_busy;
   logic          w_space;
   logic          w_issue;
   logic          w_free;

   // Output skid FIFO
   logic [DW-1:0] w_rdata;
   logic [DW-1:0] r_fifo [2];
   logic          r_fwr;
   logic          r_frd;
   logic [1:0]    r_cnt;
   logic [1:0]    w_cnt_d;
   logic [2:0]    w_occ;
   logic          r_rd_vld;
   logic          w_stb;
   logic          w_pop;
   logic          r_cyc;
   logic          w_cyc_d;

   //------------------------------------------------------------------
   // Write side: ACK_O is gated by reset so it reads 0 while held in reset
   //------------------------------------------------------------------
   assign w_ack     = RST_I & CYC_I & STB_I & ~r_full[r_wb];
   assign w_wr_last = w_ack & (r_wcnt == BodyLast);

   always_ff @(posedge CLK_I or negedge RST_I) begin
      if (!RST_I) begin
         r_wcnt <= '0;
         r_wb   <= 1'b0;
      end else if (!CYC_I) begin
         // Dropping CYC_I abandons a partial symbol
         r_wcnt <= '0;
      end else if (w_ack) begin
         if (w_wr_last) begin
            r_wcnt <= '0;
            r_wb   <= ~r_wb;
         end else begin
            r_wcnt <= r_wcnt + AW'(1);
         end
      end
   end

   //------------------------------------------------------------------
   // Read sequencer. IDLE issues the first prefix read itself so the
   // first read leaves the cycle after the bank fills.
   //------------------------------------------------------------------
   assign w_stb  = (r_cnt != 2'd0);
   assign w_pop  = w_stb & ACK_I;
   assign w_occ  = {1'b0, r_cnt} + {2'b00, r_rd_vld};
   // Room for the data of a read issued now, after this cycle's push and pop
   assign w_space = (w_occ - {2'b00, w_pop}) < 3'd2;
   assign w_busy  = (r_state != IDLE) | r_full[r_rb];
   assign w_issue = w_busy & w_space;
   assign w_raddr = (r_state == BODY) ? r_rcnt : (CpStart + r_rcnt);

   always_comb begin
      w_state_d = r_state;
      w_rcnt_d  = r_rcnt;
      w_free    = 1'b0;
      if (w_issue) begin
         unique case (r_state)
            IDLE, CP: begin
               if (r_rcnt == CpLast) begin
                  w_state_d = BODY;
                  w_rcnt_d  = '0;
               end else begin
                  w_state_d = CP;
                  w_rcnt_d  = r_rcnt + AW'(1);
               end
            end
            BODY: begin
               if (r_rcnt == BodyLast) begin
                  // Data is already on its way out of the RAM, so the bank can be refilled
                  w_free    = 1'b1;
                  w_rcnt_d  = '0;
                  w_state_d = r_full[~r_rb] ? CP : IDLE;
               end else begin
                  w_rcnt_d = r_rcnt + AW'(1);
               end
            end
            default: w_state_d = IDLE;
         endcase
      end
   end

   // Completing and freeing always hit different banks, so the two updates never collide
   always_comb begin
      w_full_d = r_full;
      if (w_free) begin
         w_full_d[r_rb] = 1'b0;
      end
      if (w_wr_last) begin
         w_full_d[r_wb] = 1'b1;
      end
   end

   always_ff @(posedge CLK_I or negedge RST_I) begin
      if (!RST_I) begin
         r_state <= IDLE;
         r_rcnt  <= '0;
         r_rb    <= 1'b0;
         r_full  <= 2'b00;
      end else begin
         r_state <= w_state_d;
         r_rcnt  <= w_rcnt_d;
         r_rb    <= r_rb ^ w_free;
         r_full  <= w_full_d;
      end
   end

   cp_dpram #(
      .DEPTH (2 * NFFT),
      .AW    (AW + 1),
      .DW    (DW)
   ) u_ram (
      .i_clk   (CLK_I),
      .i_we    (w_ack),
      .i_waddr ({r_wb, r_wcnt}),
      .i_wdata (DAT_I),
      .i_re    (w_issue),
      .i_raddr ({r_rb, w_raddr}),
      .o_rdata (w_rdata)
   );

   //------------------------------------------------------------------
   // Output skid FIFO: absorbs the one-cycle RAM latency so the head
   // stays put while the sink stalls.
   //------------------------------------------------------------------
   assign w_cnt_d = r_cnt + {1'b0, r_rd_vld} - {1'b0, w_pop};

   always_ff @(posedge CLK_I or negedge RST_I) begin
      if (!RST_I) begin
         r_fifo[0] <= '0;
         r_fifo[1] <= '0;
         r_fwr     <= 1'b0;
         r_frd     <= 1'b0;
         r_cnt     <= 2'd0;
         r_rd_vld  <= 1'b0;
      end else begin
         if (r_rd_vld) begin
            r_fifo[r_fwr] <= w_rdata;
            r_fwr         <= ~r_fwr;
         end
         if (w_pop) begin
            r_frd <= ~r_frd;
         end
         r_cnt    <= w_cnt_d;
         r_rd_vld <= w_issue;
      end
   end

   // CYC_O rises with the first valid sample and holds until nothing is queued or pending
   always_comb begin
      if (r_cyc) begin
         w_cyc_d = (w_cnt_d != 2'd0) | (w_state_d != IDLE) | w_issue;
      end else begin
         w_cyc_d = (w_cnt_d != 2'd0);
      end
   end

   always_ff @(posedge CLK_I or negedge RST_I) begin
      if (!RST_I) begin
         r_cyc <= 1'b0;
      end else begin
         r_cyc <= w_cyc_d;
      end
   end

   assign ACK_O = w_ack;
   assign STB_O = w_stb;
   assign WE_O  = w_stb;
   assign CYC_O = r_cyc;
   assign DAT_O = w_stb ? r_fifo[r_frd] : '0;

endmodule

// File: tb/tb_cp_inserter.sv
module tb_cp_inserter;

   localparam int N = 16;
   localparam int C = 4;
   localparam int L = N + C;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] dat_i;
   logic        cyc_i;
   logic        stb_i;
   logic        ack_o;
   logic [31:0] dat_o;
   logic        we_o;
   logic        stb_o;
   logic        cyc_o;
   logic        ack_i;

   cp_inserter #(
      .NFFT (N),
      .NCP  (C),
      .DW   (32)
   ) dut (
      .CLK_I (clk),
      .RST_I (rst_n),
      .DAT_I (dat_i),
      .CYC_I (cyc_i),
      .STB_I (stb_i),
      .ACK_O (ack_o),
      .DAT_O (dat_o),
      .WE_O  (we_o),
      .STB_O (stb_o),
      .CYC_O (cyc_o),
      .ACK_I (ack_i)
   );

   initial forever #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;
   int cyc    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // ACK_I driver: 0 = always high, 1 = random 30% duty, 2 = held low
   int ack_mode = 0;
   initial begin
      ack_i = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (ack_mode == 0)      ack_i = 1'b1;
         else if (ack_mode == 1) ack_i = (int'($urandom_range(0, 99)) < 30);
         else                    ack_i = 1'b0;
      end
   end

   // Output monitor: records transfers and protocol observations only
   logic [31:0] got[$];
   int          first_stb  = -1;
   int          stab_viol  = 0;
   int          cyc_viol   = 0;
   int          bubbles    = 0;
   int          bub_target = 0;
   int          clr_tok    = 0;
   int          seen_tok   = 0;
   logic        prev_stall = 1'b0;
   logic [31:0] prev_dat   = '0;

   initial begin
      forever begin
         @(negedge clk);
         if (clr_tok != seen_tok) begin
            seen_tok   = clr_tok;
            got.delete();
            first_stb  = -1;
            stab_viol  = 0;
            cyc_viol   = 0;
            bubbles    = 0;
            prev_stall = 1'b0;
         end else if (rst_n) begin
            if (stb_o && !cyc_o) cyc_viol++;
            if (prev_stall && (!stb_o || dat_o !== prev_dat)) stab_viol++;
            if (stb_o && first_stb < 0) first_stb = cyc;
            if (bub_target > 0 && !stb_o && got.size() > 0 && got.size() < bub_target)
               bubbles++;
            if (stb_o && ack_i) got.push_back(dat_o);
            prev_stall = stb_o && !ack_i;
            prev_dat   = dat_o;
         end else begin
            prev_stall = 1'b0;
         end
      end
   end

   // Reference model: each accepted symbol yields its last C samples, then all N
   logic [31:0] exp_q[$];
   int          acc_count    = 0;
   int          last_ack_cyc = 0;
   int          snap_out     = -1;

   function automatic void add_exp(input logic [31:0] s[N]);
      for (int j = 0; j < L; j++) exp_q.push_back(s[(j + N - C) % N]);
   endfunction

   task automatic clear_all();
      clr_tok++;
      exp_q.delete();
      acc_count = 0;
      snap_out  = -1;
      @(negedge clk);
      #1;
   endtask

   // Offers cnt samples of s; leaves CYC_I high. Called at posedge+2.
   task automatic push_sym(input logic [31:0] s[N], input int cnt, input int gap_pct);
      int waited;
      bit acc;
      for (int i = 0; i < cnt; i++) begin
         if (gap_pct > 0 && int'($urandom_range(0, 99)) < gap_pct) begin
            stb_i = 1'b0;
            @(posedge clk);
            #2;
         end
         cyc_i = 1'b1;
         stb_i = 1'b1;
         dat_i = s[i];
         waited = 0;
         acc = 1'b0;
         while (!acc && waited < 400) begin
            @(negedge clk);
            acc = ack_o;
            if (acc) begin
               acc_count++;
               last_ack_cyc = cyc;
               if (acc_count == 33) snap_out = got.size();
            end
            @(posedge clk);
            #2;
            waited++;
         end
         n_cmp++;
         if (!acc) begin
            n_fail++;
            $display("FAIL push_ack: sample %0d saw ACK_O=0 for 400 cycles, required ACK_O=1", i);
            stb_i = 1'b0;
            return;
         end
      end
      stb_i = 1'b0;
   endtask

   task automatic wait_out(input int n, input int budget);
      for (int t = 0; t < budget; t++) begin
         @(negedge clk);
         #1;
         if (got.size() >= n && !cyc_o) break;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      cyc_i = 1'b1;
      stb_i = 1'b1;
      dat_i = 32'hdead_beef;
      repeat (3) @(negedge clk);
      n_cmp += 5;
      if (ack_o !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b, required 0", ack_o); end
      if (stb_o !== 1'b0) begin n_fail++; $display("FAIL reset_stb: got %b, required 0", stb_o); end
      if (we_o !== 1'b0)  begin n_fail++; $display("FAIL reset_we: got %b, required 0", we_o); end
      if (cyc_o !== 1'b0) begin n_fail++; $display("FAIL reset_cyc: got %b, required 0", cyc_o); end
      if (dat_o !== 32'd0) begin n_fail++; $display("FAIL reset_dat: got %h, required 0", dat_o); end
      cyc_i = 1'b0;
      stb_i = 1'b0;
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      clear_all();
   endtask

   task automatic test_single();
      logic [31:0] s[N];
      clear_all();
      @(posedge clk);
      #2;
      for (int i = 0; i < N; i++) s[i] = 32'(i);
      add_exp(s);
      push_sym(s, N, 0);
      wait_out(L, 200);
      n_cmp++;
      if (got.size() != exp_q.size()) begin
         n_fail++;
         $display("FAIL single_count: got %0d samples, required %0d", got.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
         n_cmp++;
         if (got[i] !== exp_q[i]) begin
            n_fail++;
            $display("FAIL single_data[%0d]: got %h, required %h", i, got[i], exp_q[i]);
         end
      end
      n_cmp += 3;
      if (first_stb - last_ack_cyc != 3) begin
         n_fail++;
         $display("FAIL single_latency: got %0d cycles, required 3", first_stb - last_ack_cyc);
      end
      if (cyc_o !== 1'b0) begin n_fail++; $display("FAIL single_cyc_fall: got %b, required 0", cyc_o); end
      if (cyc_viol != 0) begin n_fail++; $display("FAIL single_cyc_cover: got %0d, required 0", cyc_viol); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] s[N];
      clear_all();
      bub_target = 6 * L;
      @(posedge clk);
      #2;
      for (int k = 0; k < 6; k++) begin
         for (int i = 0; i < N; i++) s[i] = 32'(k * 4096 + i);
         add_exp(s);
         push_sym(s, N, 0);
      end
      wait_out(6 * L, 600);
      n_cmp++;
      if (got.size() != exp_q.size()) begin
         n_fail++;
         $display("FAIL b2b_count: got %0d samples, required %0d", got.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
         n_cmp++;
         if (got[i] !== exp_q[i]) begin
            n_fail++;
            $display("FAIL b2b_data[%0d]: got %h, required %h", i, got[i], exp_q[i]);
         end
      end
      n_cmp++;
      if (bubbles != 0) begin n_fail++; $display("FAIL b2b_bubbles: got %0d, required 0", bubbles); end
      bub_target = 0;
   endtask

   task automatic test_backpressure();
      logic [31:0] s[N];
      clear_all();
      ack_mode = 1;
      @(posedge clk);
      #2;
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < N; i++) s[i] = $urandom;
         add_exp(s);
         push_sym(s, N, 20);
      end
      wait_out(3 * L, 3000);
      ack_mode = 0;
      n_cmp++;
      if (got.size() != exp_q.size()) begin
         n_fail++;
         $display("FAIL bp_count: got %0d samples, required %0d", got.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
         n_cmp++;
         if (got[i] !== exp_q[i]) begin
            n_fail++;
            $display("FAIL bp_data[%0d]: got %h, required %h", i, got[i], exp_q[i]);
         end
      end
      n_cmp += 2;
      if (stab_viol != 0) begin n_fail++; $display("FAIL bp_stable: got %0d changes, required 0", stab_viol); end
      if (cyc_viol != 0) begin n_fail++; $display("FAIL bp_cyc_cover: got %0d, required 0", cyc_viol); end
   endtask

   task automatic test_partial();
      logic [31:0] s[N];
      clear_all();
      @(posedge clk);
      #2;
      for (int i = 0; i < N; i++) s[i] = 32'(500 + i);
      push_sym(s, 10, 0);
      cyc_i = 1'b0;
      @(posedge clk);
      #2;
      for (int i = 0; i < N; i++) s[i] = 32'(100 + i);
      add_exp(s);
      push_sym(s, N, 0);
      wait_out(L, 300);
      n_cmp++;
      if (got.size() != exp_q.size()) begin
         n_fail++;
         $display("FAIL partial_count: got %0d samples, required %0d", got.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
         n_cmp++;
         if (got[i] !== exp_q[i]) begin
            n_fail++;
            $display("FAIL partial_data[%0d]: got %h, required %h", i, got[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_collision();
      logic [31:0] syms[3][N];
      int acc40;
      clear_all();
      ack_mode = 2;
      @(posedge clk);
      #2;
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < N; i++) syms[k][i] = 32'(200 + k * N + i);
         add_exp(syms[k]);
      end
      acc40 = -1;
      fork
         begin
            for (int k = 0; k < 3; k++) push_sym(syms[k], N, 0);
         end
         begin
            repeat (40) @(posedge clk);
            acc40 = acc_count;
            ack_mode = 0;
         end
      join
      wait_out(3 * L, 400);
      n_cmp += 2;
      if (acc40 != 2 * N) begin
         n_fail++;
         $display("FAIL coll_stall: got %0d accepted before release, required %0d", acc40, 2 * N);
      end
      if (snap_out < L - 3 || snap_out > L) begin
         n_fail++;
         $display("FAIL coll_resume: got %0d outputs at resume, required %0d..%0d",
                  snap_out, L - 3, L);
      end
      n_cmp++;
      if (got.size() != exp_q.size()) begin
         n_fail++;
         $display("FAIL coll_count: got %0d samples, required %0d", got.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
         n_cmp++;
         if (got[i] !== exp_q[i]) begin
            n_fail++;
            $display("FAIL coll_data[%0d]: got %h, required %h", i, got[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] s[N];
      clear_all();
      @(posedge clk);
      #2;
      for (int i = 0; i < N; i++) s[i] = 32'(300 + i);
      push_sym(s, N, 0);
      for (int t = 0; t < 200 && got.size() < C + 4; t++) @(negedge clk);
      cyc_i = 1'b1;
      stb_i = 1'b1;
      #3;
      rst_n = 1'b0;
      #1;
      n_cmp += 5;
      if (ack_o !== 1'b0) begin n_fail++; $display("FAIL rmid_ack: got %b, required 0", ack_o); end
      if (stb_o !== 1'b0) begin n_fail++; $display("FAIL rmid_stb: got %b, required 0", stb_o); end
      if (we_o !== 1'b0)  begin n_fail++; $display("FAIL rmid_we: got %b, required 0", we_o); end
      if (cyc_o !== 1'b0) begin n_fail++; $display("FAIL rmid_cyc: got %b, required 0", cyc_o); end
      if (dat_o !== 32'd0) begin n_fail++; $display("FAIL rmid_dat: got %h, required 0", dat_o); end
      cyc_i = 1'b0;
      stb_i = 1'b0;
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      clear_all();
      @(posedge clk);
      #2;
      for (int i = 0; i < N; i++) s[i] = 32'(i);
      add_exp(s);
      push_sym(s, N, 0);
      wait_out(L, 300);
      n_cmp++;
      if (got.size() != exp_q.size()) begin
         n_fail++;
         $display("FAIL rmid_count: got %0d samples, required %0d", got.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
         n_cmp++;
         if (got[i] !== exp_q[i]) begin
            n_fail++;
            $display("FAIL rmid_data[%0d]: got %h, required %h", i, got[i], exp_q[i]);
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      cyc_i = 1'b0;
      stb_i = 1'b0;
      dat_i = '0;
      test_reset();
      test_single();
      test_back_to_back();
      test_backpressure();
      test_partial();
      test_collision();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
